// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
// Latency: n/a (types and defaults only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;
    localparam int STARVE_DEF  = 3;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port, memory port and stall for the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req/ack on the CPU ports, req/ready on the memory port.
// Modports: slave = arbiter side, master = CPU + memory side.
interface mem_port_arbiter_if import mem_port_arbiter_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    // instruction fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    // data port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          bus_err;
    // memory port
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ready;
    logic [DW-1:0] m_rdata;
    // CPU freeze
    logic          stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, bus_err,
               m_req, m_we, m_addr, m_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, bus_err,
               m_req, m_we, m_addr, m_wdata, stall
    );

endinterface

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Per-transaction wait counter; o_expire flags the TIMEOUT-th enabled cycle.
// Latency: o_expire is combinational from the count and i_en.
// Backpressure: none; i_clr has priority over i_en.
// Ports: clock, resetn, i_clr (restart), i_en (count this cycle), o_expire.
module arb_timeout_ctr import mem_port_arbiter_pkg::*; #(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic resetn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    // At least 4 bits, and always wide enough to hold TIMEOUT itself.
    localparam int CW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt counts waiting cycles already spent, so count TIMEOUT-1 while
    // still waiting means this is the TIMEOUT-th cycle without completion.
    assign o_expire = i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data ports, one transaction at a time.
// Latency: req raised after edge 0 -> m_req at edge 1 -> ack at edge 2 with zero-wait memory.
// Backpressure: requesters hold req until ack; stall is high while any request is unacked.
// Ports: clock, resetn, bus (slave modport: fetch port, data port, memory port, bus_err, stall).
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int STARVE  = STARVE_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clock,
    input  logic               resetn,
    mem_port_arbiter_if.slave  bus
);
    localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

    state_t        r_state, w_state_nxt;
    owner_t        r_owner, w_owner;
    logic [SW-1:0] r_starve, w_starve;
    logic          r_m_req, w_m_req;
    logic          r_m_we, w_m_we;
    logic [AW-1:0] r_m_addr, w_m_addr;
    logic [DW-1:0] r_m_wdata, w_m_wdata;
    logic          r_if_ack, w_if_ack;
    logic          r_d_ack, w_d_ack;
    logic          r_bus_err, w_bus_err;
    logic [DW-1:0] r_if_rdata, w_if_rdata;
    logic [DW-1:0] r_d_rdata, w_d_rdata;

    logic w_any_req;
    logic w_grant_if;
    logic w_tmr_clr;
    logic w_tmr_en;
    logic w_expire;
    logic w_finish;

    assign w_any_req  = bus.if_req | bus.d_req;
    // Data wins a tie unless fetch has already been passed over STARVE times.
    assign w_grant_if = bus.if_req & (~bus.d_req | (r_starve == SW'(STARVE)));
    assign w_tmr_clr  = (r_state == ST_IDLE) & w_any_req;
    assign w_tmr_en   = (r_state == ST_BUSY) & ~bus.m_ready;
    // m_ready takes precedence over a timeout landing in the same cycle.
    assign w_finish   = (r_state == ST_BUSY) & (bus.m_ready | w_expire);

    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock    (clock),
        .resetn   (resetn),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );

    // ---- state register ----
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- next state ----
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_state_nxt = ST_BUSY;
            ST_BUSY: if (bus.m_ready || w_expire) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---- next values of the registered outputs ----
    always_comb begin
        w_owner    = r_owner;
        w_starve   = r_starve;
        w_m_req    = r_m_req;
        w_m_we     = r_m_we;
        w_m_addr   = r_m_addr;
        w_m_wdata  = r_m_wdata;
        w_if_rdata = r_if_rdata;
        w_d_rdata  = r_d_rdata;
        w_if_ack   = 1'b0;
        w_d_ack    = 1'b0;
        w_bus_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_m_req = 1'b1;
                    if (w_grant_if) begin
                        w_owner  = OWN_IF;
                        w_m_we   = 1'b0;
                        w_m_addr = bus.if_addr;
                        w_starve = '0;
                    end else begin
                        w_owner   = OWN_D;
                        w_m_we    = bus.d_we;
                        w_m_addr  = bus.d_addr;
                        w_m_wdata = bus.d_wdata;
                        if (bus.if_req && (r_starve != SW'(STARVE))) begin
                            w_starve = r_starve + 1'b1;
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (w_finish) begin
                    w_m_req  = 1'b0;
                    w_m_we   = 1'b0;
                    // bus_err is registered alongside the ack, so it is the
                    // error flag for the RESP cycle.
                    w_bus_err = ~bus.m_ready;
                    if (r_owner == OWN_IF) begin
                        w_if_ack = 1'b1;
                    end else begin
                        w_d_ack = 1'b1;
                    end
                    if (bus.m_ready && !r_m_we) begin
                        if (r_owner == OWN_IF) begin
                            w_if_rdata = bus.m_rdata;
                        end else begin
                            w_d_rdata = bus.m_rdata;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // ---- output registers ----
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_owner    <= OWN_IF;
            r_starve   <= '0;
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_if_ack   <= 1'b0;
            r_d_ack    <= 1'b0;
            r_bus_err  <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_owner    <= w_owner;
            r_starve   <= w_starve;
            r_m_req    <= w_m_req;
            r_m_we     <= w_m_we;
            r_m_addr   <= w_m_addr;
            r_m_wdata  <= w_m_wdata;
            r_if_ack   <= w_if_ack;
            r_d_ack    <= w_d_ack;
            r_bus_err  <= w_bus_err;
            r_if_rdata <= w_if_rdata;
            r_d_rdata  <= w_d_rdata;
        end
    end

    assign bus.m_req    = r_m_req;
    assign bus.m_we     = r_m_we;
    assign bus.m_addr   = r_m_addr;
    assign bus.m_wdata  = r_m_wdata;
    assign bus.if_ack   = r_if_ack;
    assign bus.d_ack    = r_d_ack;
    assign bus.bus_err  = r_bus_err;
    assign bus.if_rdata = r_if_rdata;
    assign bus.d_rdata  = r_d_rdata;
    // Unregistered so the CPU freezes in the same cycle a request appears.
    assign bus.stall    = (bus.if_req & ~r_if_ack) | (bus.d_req & ~r_d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed fetch/load/store/timeout/reset cases.
// Latency: checks the 2-edge minimum request-to-ack path and the 15-cycle abort.
// Backpressure: memory model inserts wait states or never answers.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    resp_t  if_exp_q[$];
    resp_t  d_exp_q[$];
    grant_t grant_q[$];

    logic [31:0] mem [logic [31:0]];
    int mem_lat  = 0;
    bit mem_dead = 0;
    int last_busy_len = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    initial begin
        int wcnt = 0;
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;
        forever begin
            @(posedge clock); #1;
            bus.m_ready = 1'b0;
            if (bus.m_req && !mem_dead) begin
                if (wcnt == mem_lat) begin
                    bus.m_ready = 1'b1;
                    if (bus.m_we) begin
                        mem[bus.m_addr] = bus.m_wdata;
                    end else begin
                        bus.m_rdata = mem.exists(bus.m_addr) ? mem[bus.m_addr] : 32'h0;
                    end
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // ---------------- memory-side monitor: grant order and stability ----------------
    initial begin
        logic   prev_req = 1'b0;
        bit     unstable = 0;
        int     busy_len = 0;
        grant_t cur;
        grant_t e;
        forever begin
            @(posedge clock); #1;
            if (bus.m_req && !prev_req) begin
                cur      = '{bus.m_we, bus.m_addr, bus.m_wdata};
                unstable = 0;
                busy_len = 1;
                if (grant_q.size() == 0) begin
                    chk("grant_spurious", bus.m_req, 1'b0);
                end else begin
                    e = grant_q.pop_front();
                    chk("grant_we", bus.m_we, e.we);
                    chk("grant_addr", bus.m_addr, e.addr);
                    if (e.we) chk("grant_wdata", bus.m_wdata, e.wdata);
                end
            end else if (bus.m_req) begin
                busy_len++;
                if ({bus.m_we, bus.m_addr, bus.m_wdata} !== cur) unstable = 1;
            end else if (prev_req) begin
                chk("m_stable", unstable, 0);
                last_busy_len = busy_len;
            end
            prev_req = bus.m_req;
        end
    end

    // ---------------- ack monitor: pops expected responses ----------------
    initial begin
        resp_t e;
        forever begin
            @(posedge clock); #1;
            if (bus.if_ack) begin
                chk("ack_exclusive", bus.d_ack, 1'b0);
                if (if_exp_q.size() == 0) begin
                    chk("if_ack_spurious", bus.if_ack, 1'b0);
                end else begin
                    e = if_exp_q.pop_front();
                    chk("if_rdata", bus.if_rdata, e.rdata);
                    chk("if_bus_err", bus.bus_err, e.err);
                end
            end
            if (bus.d_ack) begin
                if (d_exp_q.size() == 0) begin
                    chk("d_ack_spurious", bus.d_ack, 1'b0);
                end else begin
                    e = d_exp_q.pop_front();
                    chk("d_rdata", bus.d_rdata, e.rdata);
                    chk("d_bus_err", bus.bus_err, e.err);
                end
            end
        end
    end

    // ---------------- requesters ----------------
    task automatic if_txn(input logic [31:0] addr, input logic [31:0] exp_rd,
                          input logic exp_err, output int lat);
        if_exp_q.push_back('{exp_err, exp_rd});
        bus.if_addr = addr;
        bus.if_req  = 1'b1;
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!bus.if_ack && lat < 100);
        chk("if_ack_seen", bus.if_ack, 1'b1);
        bus.if_req = 1'b0;
    endtask

    task automatic d_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err, output int lat);
        d_exp_q.push_back('{exp_err, exp_rd});
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_req   = 1'b1;
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!bus.d_ack && lat < 100);
        chk("d_ack_seen", bus.d_ack, 1'b1);
        bus.d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int lat2;
        logic [31:0] t3_dat [7];
        t3_dat = '{32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003,
                   32'hA5A5_0004, 32'hA5A5_0005, 32'hA5A5_0006};

        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        mem[32'h40]  = 32'h8C22_0004;
        mem[32'h44]  = 32'h8C22_0008;
        mem[32'h48]  = 32'h8C22_000C;
        mem[32'h4C]  = 32'h8C22_0010;
        mem[32'h100] = 32'hDEAD_BEEF;
        for (int i = 0; i < 7; i++) mem[32'h300 + 32'(4 * i)] = t3_dat[i];

        // reset state
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_m_req", bus.m_req, 1'b0);
        chk("rst_m_we", bus.m_we, 1'b0);
        chk("rst_m_addr", bus.m_addr, 32'h0);
        chk("rst_m_wdata", bus.m_wdata, 32'h0);
        chk("rst_if_ack", bus.if_ack, 1'b0);
        chk("rst_d_ack", bus.d_ack, 1'b0);
        chk("rst_bus_err", bus.bus_err, 1'b0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        chk("rst_stall", bus.stall, 1'b0);
        resetn = 1'b1;
        @(posedge clock); #1;

        // 1: fetch only, zero-wait memory
        grant_q.push_back('{1'b0, 32'h40, 32'h0});
        if_txn(32'h40, 32'h8C22_0004, 1'b0, lat);
        chk("t1_latency", lat, 2);
        chk("t1_stall_after", bus.stall, 1'b0);
        @(posedge clock); #1;

        // 2: simultaneous requests, data first
        grant_q.push_back('{1'b0, 32'h100, 32'h0});
        grant_q.push_back('{1'b0, 32'h44, 32'h0});
        fork
            d_txn(1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, lat);
            if_txn(32'h44, 32'h8C22_0008, 1'b0, lat2);
        join
        chk("t2_d_latency", lat, 2);
        chk("t2_if_latency", lat2, 5);
        @(posedge clock); #1;

        // 3: data held continuously, fetch waiting: D D D IF D D D IF D
        for (int i = 0; i < 3; i++) grant_q.push_back('{1'b0, 32'h300 + 32'(4 * i), 32'h0});
        grant_q.push_back('{1'b0, 32'h48, 32'h0});
        for (int i = 3; i < 6; i++) grant_q.push_back('{1'b0, 32'h300 + 32'(4 * i), 32'h0});
        grant_q.push_back('{1'b0, 32'h4C, 32'h0});
        grant_q.push_back('{1'b0, 32'h318, 32'h0});
        fork
            begin
                int dl;
                for (int i = 0; i < 7; i++) d_txn(1'b0, 32'h300 + 32'(4 * i), 32'h0, t3_dat[i], 1'b0, dl);
            end
            begin
                int il;
                if_txn(32'h48, 32'h8C22_000C, 1'b0, il);
                if_txn(32'h4C, 32'h8C22_0010, 1'b0, il);
            end
        join
        @(posedge clock); #1;

        // 4: store with two wait states; d_rdata keeps the last load value
        mem_lat = 2;
        grant_q.push_back('{1'b1, 32'h200, 32'h1234_5678});
        d_txn(1'b1, 32'h200, 32'h1234_5678, 32'hA5A5_0006, 1'b0, lat);
        chk("t4_latency", lat, 4);
        @(posedge clock); #1;
        chk("t4_busy_len", last_busy_len, 3);
        chk("t4_mem_written", mem[32'h200], 32'h1234_5678);
        mem_lat = 0;
        grant_q.push_back('{1'b0, 32'h200, 32'h0});
        d_txn(1'b0, 32'h200, 32'h0, 32'h1234_5678, 1'b0, lat);
        @(posedge clock); #1;

        // 5: memory never answers -> abort with bus_err, if_rdata unchanged
        mem_dead = 1;
        grant_q.push_back('{1'b0, 32'h80, 32'h0});
        fork
            if_txn(32'h80, 32'h8C22_0010, 1'b1, lat);
            begin
                repeat (5) @(negedge clock);
                chk("t5_stall_wait", bus.stall, 1'b1);
            end
        join
        chk("t5_latency", lat, 16);
        @(posedge clock); #1;
        chk("t5_busy_len", last_busy_len, 15);
        chk("t5_m_req_low", bus.m_req, 1'b0);
        chk("t5_err_cleared", bus.bus_err, 1'b0);
        chk("t5_stall_low", bus.stall, 1'b0);
        mem_dead = 0;
        @(posedge clock); #1;

        // 6: reset in the middle of BUSY
        mem_dead = 1;
        grant_q.push_back('{1'b0, 32'h84, 32'h0});
        bus.if_addr = 32'h84;
        bus.if_req  = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("t6_busy_before", bus.m_req, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_m_req", bus.m_req, 1'b0);
        chk("t6_if_ack", bus.if_ack, 1'b0);
        chk("t6_if_rdata", bus.if_rdata, 32'h0);
        chk("t6_d_rdata", bus.d_rdata, 32'h0);
        chk("t6_m_addr", bus.m_addr, 32'h0);
        chk("t6_bus_err", bus.bus_err, 1'b0);
        bus.if_req = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn   = 1'b1;
        mem_dead = 0;
        @(posedge clock); #1;
        grant_q.push_back('{1'b0, 32'h40, 32'h0});
        if_txn(32'h40, 32'h8C22_0004, 1'b0, lat);
        chk("t6_latency_after", lat, 2);

        repeat (3) @(posedge clock);
        #1;
        chk("if_q_drained", if_exp_q.size(), 0);
        chk("d_q_drained", d_exp_q.size(), 0);
        chk("grant_q_drained", grant_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
